// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB constants used by the arbiter, register file and reservation stations.
package cdb_arbiter_pkg;
    localparam int CDB_N_REQ   = 4;
    localparam int CDB_LABEL_W = 5;
    localparam int CDB_DATA_W  = 32;

    // Label 0 means "no producer"; such results are consumed but never broadcast.
    localparam logic [CDB_LABEL_W-1:0] NULL_LABEL = '0;
endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-port and broadcast bundle between functional units and the CDB arbiter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ   = CDB_N_REQ,
    parameter int LABEL_W = CDB_LABEL_W,
    parameter int DATA_W  = CDB_DATA_W
);
    logic                       flush;
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ*LABEL_W-1:0]   req_label;
    logic [N_REQ*DATA_W-1:0]    req_data;
    logic [N_REQ-1:0]           req_ready;
    logic                       bc_en;
    logic [LABEL_W-1:0]         bc_label;
    logic [DATA_W-1:0]          bc_data;

    modport master (
        output flush, req_valid, req_label, req_data,
        input  req_ready, bc_en, bc_label, bc_data
    );

    modport slave (
        input  flush, req_valid, req_label, req_data,
        output req_ready, bc_en, bc_label, bc_data
    );
endinterface

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module cdb_arbiter_rr #(
    parameter int N = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);
    logic [N-1:0]   hi_mask;
    logic [2*N-1:0] dbl;
    logic           found;

    // Lower half holds only requests at/after ptr; upper half supplies the wrap-around.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
        dbl   = {req, req & hi_mask};
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && dbl[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && dbl[N+i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-port 1-entry result buffers, round-robin grant, registered broadcast.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ   = CDB_N_REQ,
    parameter int LABEL_W = CDB_LABEL_W,
    parameter int DATA_W  = CDB_DATA_W
) (
    input logic          clk,
    input logic          nRST,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   pend_p0;
    logic [LABEL_W-1:0] lab_p0 [N_REQ];
    logic [DATA_W-1:0]  dat_p0 [N_REQ];
    logic [PTR_W-1:0]   ptr;

    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   ready;
    logic [N_REQ-1:0]   accept;
    logic [N_REQ-1:0]   keep;
    logic [PTR_W-1:0]   gidx;
    logic [PTR_W-1:0]   next_ptr;
    logic [LABEL_W-1:0] gnt_label;
    logic [DATA_W-1:0]  gnt_data;

    logic               vld_p1;
    logic [LABEL_W-1:0] label_p1;
    logic [DATA_W-1:0]  data_p1;

    cdb_arbiter_rr #(.N(N_REQ)) u_rr (
        .req   (pend_p0),
        .ptr   (ptr),
        .grant (grant)
    );

    // A granted buffer frees up in the same cycle, allowing back-to-back accepts.
    assign ready  = {N_REQ{nRST & ~bus.flush}} & (~pend_p0 | grant);
    assign accept = bus.req_valid & ready;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            keep[i] = bus.req_label[i*LABEL_W +: LABEL_W] != LABEL_W'(NULL_LABEL);
        end
    end

    always_comb begin
        gidx      = '0;
        gnt_label = '0;
        gnt_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gidx      = PTR_W'(i);
                gnt_label = lab_p0[i];
                gnt_data  = dat_p0[i];
            end
        end
        next_ptr = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    end

    // Stage p0: buffer occupancy and rotation pointer
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            pend_p0 <= '0;
            ptr     <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (bus.flush)
                    pend_p0[i] <= 1'b0;
                else if (accept[i])
                    pend_p0[i] <= keep[i];
                else if (grant[i])
                    pend_p0[i] <= 1'b0;
            end
            if (!bus.flush && (|grant))
                ptr <= next_ptr;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i] && keep[i]) begin
                lab_p0[i] <= bus.req_label[i*LABEL_W +: LABEL_W];
                dat_p0[i] <= bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Stage p1: registered broadcast, zeroed when idle or squashed
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            vld_p1   <= 1'b0;
            label_p1 <= '0;
            data_p1  <= '0;
        end else if (bus.flush || !(|grant)) begin
            vld_p1   <= 1'b0;
            label_p1 <= '0;
            data_p1  <= '0;
        end else begin
            vld_p1   <= 1'b1;
            label_p1 <= gnt_label;
            data_p1  <= gnt_data;
        end
    end

    assign bus.req_ready = ready;
    assign bus.bc_en     = vld_p1;
    assign bus.bc_label  = label_p1;
    assign bus.bc_data   = data_p1;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;
    logic clk;
    logic nRST;
    int   checks;
    int   failures;

    cdb_arbiter_if #(.N_REQ(4), .LABEL_W(5), .DATA_W(32)) bus ();

    cdb_arbiter dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs;
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        bus.req_label = '0;
        bus.req_data  = '0;
    endtask

    task automatic set_port(input int p, input logic [4:0] l, input logic [31:0] d);
        bus.req_label[p*5 +: 5]  = l;
        bus.req_data[p*32 +: 32] = d;
    endtask

    task automatic do_reset;
        @(negedge clk);
        clear_inputs();
        nRST = 1'b0;
        repeat (2) @(negedge clk);
        nRST = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        nRST = 1'b0;
        bus.req_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_port(i, 5'(i + 1), 32'hFFFF_0000 + i);
        #1;
        checks++;
        if (bus.req_ready !== 4'h0) begin
            failures++;
            $display("FAIL reset_ready: got %b expected %b", bus.req_ready, 4'h0);
        end
        @(negedge clk);
        checks++;
        if (bus.bc_en !== 1'b0 || bus.bc_label !== 5'd0 || bus.bc_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_bc: got en=%b label=%0d data=%h expected 0/0/0",
                     bus.bc_en, bus.bc_label, bus.bc_data);
        end
        checks++;
        if (bus.req_ready !== 4'h0) begin
            failures++;
            $display("FAIL reset_ready_held: got %b expected %b", bus.req_ready, 4'h0);
        end
        nRST = 1'b1;
        bus.req_valid = 4'h0;
        #1;
        checks++;
        if (bus.req_ready !== 4'hF) begin
            failures++;
            $display("FAIL reset_release_ready: got %b expected %b", bus.req_ready, 4'hF);
        end
    endtask

    task automatic test_single;
        do_reset();
        bus.req_valid = 4'b0100;
        set_port(2, 5'd7, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        checks++;
        if (bus.bc_en !== 1'b0) begin
            failures++;
            $display("FAIL single_early: got bc_en=%b expected 0", bus.bc_en);
        end
        @(negedge clk);
        checks++;
        if (bus.bc_en !== 1'b1 || bus.bc_label !== 5'd7 || bus.bc_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_bc: got en=%b label=%0d data=%h expected 1/7/deadbeef",
                     bus.bc_en, bus.bc_label, bus.bc_data);
        end
        @(negedge clk);
        checks++;
        if (bus.bc_en !== 1'b0 || bus.bc_label !== 5'd0 || bus.bc_data !== 32'd0) begin
            failures++;
            $display("FAIL single_after: got en=%b label=%0d data=%h expected 0/0/0",
                     bus.bc_en, bus.bc_label, bus.bc_data);
        end
    endtask

    task automatic test_contention;
        logic [3:0] exp_ready [5];
        exp_ready = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
        do_reset();
        bus.req_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_port(i, 5'(i + 1), 32'hA000_0000 + i);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.req_valid = 4'h0;
            if (k < 5) begin
                checks++;
                if (bus.req_ready !== exp_ready[k]) begin
                    failures++;
                    $display("FAIL contention_ready[%0d]: got %b expected %b",
                             k, bus.req_ready, exp_ready[k]);
                end
            end
            checks++;
            if (k == 0 || k == 5) begin
                if (bus.bc_en !== 1'b0) begin
                    failures++;
                    $display("FAIL contention_idle[%0d]: got bc_en=%b expected 0", k, bus.bc_en);
                end
            end else if (bus.bc_en !== 1'b1 || bus.bc_label !== 5'(k)
                         || bus.bc_data !== 32'hA000_0000 + 32'(k - 1)) begin
                failures++;
                $display("FAIL contention_bc[%0d]: got en=%b label=%0d data=%h expected 1/%0d/%h",
                         k, bus.bc_en, bus.bc_label, bus.bc_data, k, 32'hA000_0000 + 32'(k - 1));
            end
        end
    endtask

    task automatic test_round_robin;
        logic [4:0] exp_lab [8];
        logic [4:0] l0;
        logic [4:0] l3;
        logic       a0;
        logic       a3;
        exp_lab = '{5'd1, 5'd16, 5'd2, 5'd17, 5'd3, 5'd18, 5'd4, 5'd19};
        do_reset();
        l0 = 5'd1;
        l3 = 5'd16;
        bus.req_valid = 4'b1001;
        set_port(0, l0, 32'(l0));
        set_port(3, l3, 32'(l3));
        #1;
        a0 = bus.req_ready[0];
        a3 = bus.req_ready[3];
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (a0) l0 = l0 + 5'd1;
            if (a3) l3 = l3 + 5'd1;
            checks++;
            if (c == 0) begin
                if (bus.bc_en !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_first: got bc_en=%b expected 0", bus.bc_en);
                end
            end else if (bus.bc_en !== 1'b1 || bus.bc_label !== exp_lab[c-1]
                         || bus.bc_data !== 32'(exp_lab[c-1])) begin
                failures++;
                $display("FAIL rr_bc[%0d]: got en=%b label=%0d data=%0d expected 1/%0d/%0d",
                         c, bus.bc_en, bus.bc_label, bus.bc_data, exp_lab[c-1], exp_lab[c-1]);
            end
            set_port(0, l0, 32'(l0));
            set_port(3, l3, 32'(l3));
            #1;
            a0 = bus.req_ready[0];
            a3 = bus.req_ready[3];
        end
        bus.req_valid = 4'h0;
    endtask

    task automatic test_flush;
        do_reset();
        bus.req_valid = 4'b0110;
        set_port(1, 5'd5, 32'h0000_0005);
        set_port(2, 5'd6, 32'h0000_0006);
        @(negedge clk);
        bus.req_valid = 4'h0;
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'h0) begin
            failures++;
            $display("FAIL flush_ready: got %b expected %b", bus.req_ready, 4'h0);
        end
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        checks++;
        if (bus.bc_en !== 1'b0 || bus.req_ready !== 4'hF) begin
            failures++;
            $display("FAIL flush_after: got en=%b ready=%b expected 0/1111", bus.bc_en, bus.req_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.bc_en !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_bc: got bc_en=%b expected 0", bus.bc_en);
        end
        bus.req_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_port(i, 5'(21 + i), 32'(21 + i));
        @(negedge clk);
        bus.req_valid = 4'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.bc_en !== 1'b1 || bus.bc_label !== 5'(21 + k)) begin
                failures++;
                $display("FAIL flush_ptr_order[%0d]: got en=%b label=%0d expected 1/%0d",
                         k, bus.bc_en, bus.bc_label, 21 + k);
            end
        end
    endtask

    task automatic test_null_label;
        do_reset();
        bus.req_valid = 4'b0011;
        set_port(0, 5'd0, 32'h0000_1234);
        set_port(1, 5'd9, 32'h0000_0099);
        #1;
        checks++;
        if (bus.req_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL null_ready_pre: got %b expected 1", bus.req_ready[0]);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.req_valid = 4'b0001;
            #1;
            checks++;
            if (bus.req_ready[0] !== 1'b1) begin
                failures++;
                $display("FAIL null_ready[%0d]: got %b expected 1", k, bus.req_ready[0]);
            end
            checks++;
            if (k == 1) begin
                if (bus.bc_en !== 1'b1 || bus.bc_label !== 5'd9 || bus.bc_data !== 32'h99) begin
                    failures++;
                    $display("FAIL null_bc: got en=%b label=%0d data=%h expected 1/9/99",
                             bus.bc_en, bus.bc_label, bus.bc_data);
                end
            end else if (bus.bc_en !== 1'b0) begin
                failures++;
                $display("FAIL null_idle[%0d]: got bc_en=%b label=%0d expected 0",
                         k, bus.bc_en, bus.bc_label);
            end
        end
        bus.req_valid = 4'h0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.req_valid = 4'b0110;
        set_port(1, 5'd3, 32'h0000_0003);
        set_port(2, 5'd4, 32'h0000_0004);
        @(negedge clk);
        bus.req_valid = 4'h0;
        @(negedge clk);
        checks++;
        if (bus.bc_en !== 1'b1 || bus.bc_label !== 5'd3) begin
            failures++;
            $display("FAIL midrst_pre: got en=%b label=%0d expected 1/3", bus.bc_en, bus.bc_label);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if (bus.bc_en !== 1'b0 || bus.bc_label !== 5'd0 || bus.req_ready !== 4'h0) begin
            failures++;
            $display("FAIL midrst_clear: got en=%b label=%0d ready=%b expected 0/0/0000",
                     bus.bc_en, bus.bc_label, bus.req_ready);
        end
        @(negedge clk);
        nRST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.bc_en !== 1'b0) begin
                failures++;
                $display("FAIL midrst_lost[%0d]: got bc_en=%b label=%0d expected 0",
                         k, bus.bc_en, bus.bc_label);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nRST     = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_flush();
        test_null_label();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
